// File: rtl/tri_ser_pkg.sv
// Shared types and default parameter values for the tristate serial driver.
package tri_ser_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int DIV_DEF      = 4;
    localparam int TURN_CYC_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        DRIVE = 2'd2,
        TRAIL = 2'd3
    } state_t;

endpackage

// File: rtl/tri_ser_tick.sv
// Bit-period timer: one-clock tick every DIV clocks while en is high.
// The count restarts from zero whenever en is low.
module tri_ser_tick
    import tri_ser_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/tri_ser_driver.sv
// Serializer feeding an external tristate buffer, with bus-release turnaround
// around each drive window. Define TRI_SER_PARITY_EN to append an even-parity bit.
module tri_ser_driver
    import tri_ser_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DIV      = DIV_DEF,
    parameter int TURN_CYC = TURN_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              o_en,
    output logic              o_dat,
    output logic              busy,
    output logic              done
);

`ifdef TRI_SER_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int BW = $clog2(NBITS + 1);
    localparam int TW = $clog2(TURN_CYC + 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

    state_t           state;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] shreg_shifted;
    logic [NBITS-1:0] load_word;
    logic [BW-1:0]    bit_cnt;
    logic [TW-1:0]    turn_cnt;
    logic             tick;

`ifdef TRI_SER_PARITY_EN
    assign load_word = {tx_data, ^tx_data};
`else
    assign load_word = tx_data;
`endif
    assign shreg_shifted = shreg << 1;

    tri_ser_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state == DRIVE),
        .tick (tick)
    );

    // o_en/o_dat are set from the next-state decision so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            turn_cnt <= '0;
            tx_ready <= 1'b0;
            o_en     <= 1'b0;
            o_dat    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        shreg    <= load_word;
                        bit_cnt  <= '0;
                        turn_cnt <= '0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (TURN_CYC == 0) begin
                            state <= DRIVE;
                            o_en  <= 1'b1;
                            o_dat <= load_word[NBITS-1];
                        end else begin
                            state <= LEAD;
                        end
                    end
                end
                LEAD: begin
                    if (turn_cnt == TURN_LAST) begin
                        state    <= DRIVE;
                        turn_cnt <= '0;
                        o_en     <= 1'b1;
                        o_dat    <= shreg[NBITS-1];
                    end else begin
                        turn_cnt <= turn_cnt + TW'(1);
                    end
                end
                DRIVE: begin
                    if (tick) begin
                        if (bit_cnt == BIT_LAST) begin
                            o_en    <= 1'b0;
                            o_dat   <= 1'b0;
                            bit_cnt <= '0;
                            if (TURN_CYC == 0) begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                tx_ready <= 1'b1;
                            end else begin
                                state <= TRAIL;
                            end
                        end else begin
                            shreg   <= shreg_shifted;
                            o_dat   <= shreg_shifted[NBITS-1];
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                TRAIL: begin
                    if (turn_cnt == TURN_LAST) begin
                        state    <= IDLE;
                        turn_cnt <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        tx_ready <= 1'b1;
                    end else begin
                        turn_cnt <= turn_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_ser_driver.sv
// Scoreboard bench for tri_ser_driver: stimulus queues expected drive windows,
// a negedge monitor checks each window, the turnaround gap and the done pulse.
module tb_tri_ser_driver;

    localparam int DATA_W   = 8;
    localparam int DIV      = 4;
    localparam int TURN_CYC = 2;
`ifdef TRI_SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB      = DATA_W + int'(PAR);
    localparam int B2B_GAP = 5;   // 2 TRAIL + 1 done/IDLE + 2 LEAD clocks

    typedef struct {
        logic [8:0] bits;
        int         nbits;
        int         nsamp;
        bit         no_done;
        int         gap;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, o_en, o_dat, busy, done;
    logic [7:0] f_tx_data;
    logic       f_tx_valid;
    logic       f_tx_ready, f_o_en, f_o_dat, f_busy, f_done;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t cur;
    logic samp[$];
    int   low_run = 0;
    int   win_gap = 0;
    int   dcount  = -1;
    bit   in_win  = 1'b0;

    tri_ser_driver #(.DATA_W(DATA_W), .DIV(DIV), .TURN_CYC(TURN_CYC)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .o_en(o_en), .o_dat(o_dat), .busy(busy), .done(done)
    );

    tri_ser_driver #(.DATA_W(DATA_W), .DIV(1), .TURN_CYC(0)) dut_fast (
        .clk(clk), .rst(rst), .tx_data(f_tx_data), .tx_valid(f_tx_valid),
        .tx_ready(f_tx_ready), .o_en(f_o_en), .o_dat(f_o_dat), .busy(f_busy), .done(f_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] w, input logic p, input int gap);
        exp_t e;
        e.bits    = PAR ? {w, p} : {1'b0, w};
        e.nbits   = NB;
        e.nsamp   = NB * DIV;
        e.no_done = 1'b0;
        e.gap     = gap;
        return e;
    endfunction

    // Monitor: collect o_dat while o_en is high, score each window when it closes.
    always @(negedge clk) begin
        if (o_en === 1'b1) begin
            if (!in_win) begin
                in_win  = 1'b1;
                win_gap = low_run;
                samp.delete();
            end
            samp.push_back(o_dat);
            low_run = 0;
        end else begin
            chk("odat_when_released", 32'(o_dat), 32'd0);
            low_run++;
            if (in_win) begin
                in_win = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_window_len", 32'(samp.size()), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("window_len", 32'(samp.size()), 32'(cur.nsamp));
                    for (int i = 0; i < samp.size() && i < cur.nsamp; i++)
                        chk("stream_bit", 32'(samp[i]), 32'(cur.bits[cur.nbits-1-i/DIV]));
                    if (cur.gap >= 0) chk("b2b_gap", 32'(win_gap), 32'(cur.gap));
                    dcount = cur.no_done ? -1 : TURN_CYC;
                end
            end
        end
        if (dcount == 0) begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("ready_at_done", 32'(tx_ready), 32'd1);
            dcount = -1;
        end else begin
            chk("no_stray_done", 32'(done), 32'd0);
            if (dcount > 0) dcount--;
        end
        if (rst) low_run = 0;
    end

    task automatic send(input exp_t e, input logic [7:0] w, input bit keep_valid);
        int n;
        tx_data  = w;
        tx_valid = 1'b1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!keep_valid) tx_valid = 1'b0;
    endtask

    task automatic check_latency(input string name);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (o_en !== 1'b1 && lat < 100);
        chk(name, 32'(lat), 32'(TURN_CYC + 1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy === 1'b0 && tx_ready === 1'b1) && n < 300);
        if (n >= 300) chk("idle_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   n;
        logic [8:0] fexp;

        rst        = 1'b1;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        f_tx_data  = 8'h00;
        f_tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_o_en", 32'(o_en), 32'd0);
        chk("rst_o_dat", 32'(o_dat), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(tx_ready), 32'd1);

        // 0xA5, latency and stream
        send(mk(8'hA5, 1'b0, -1), 8'hA5, 1'b0);
        check_latency("lat_a5");
        chk("busy_in_drive", 32'(busy), 32'd1);
        wait_idle();

        // 0xA5 then 0x07 (parity 0 and 1 when enabled)
        send(mk(8'hA5, 1'b0, -1), 8'hA5, 1'b0);
        wait_idle();
        send(mk(8'h07, 1'b1, -1), 8'h07, 1'b0);
        wait_idle();

        // back-to-back with tx_valid held: 0xFF then 0x00
        send(mk(8'hFF, 1'b0, -1), 8'hFF, 1'b1);
        tx_data = 8'h00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_ready !== 1'b1 && n < 200);
        chk("b2b_accept_on_done", 32'(done), 32'd1);
        exp_q.push_back(mk(8'h00, 1'b0, B2B_GAP));
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check_latency("lat_b2b");
        wait_idle();

        // new data offered while busy must be ignored
        send(mk(8'hC3, 1'b0, -1), 8'hC3, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tx_valid = ~tx_valid;
            tx_data  = (k % 2 == 0) ? 8'h00 : 8'hFF;
        end
        tx_valid = 1'b0;
        wait_idle();
        repeat (6) @(negedge clk);
        chk("no_extra_accept", 32'(busy), 32'd0);

        // reset during the third bit of 0x3C
        e = mk(8'h3C, 1'b0, -1);
        e.nsamp   = 2 * DIV + 2;
        e.no_done = 1'b1;
        send(e, 8'h3C, 1'b0);
        check_latency("lat_3c");
        repeat (2 * DIV + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_o_en", 32'(o_en), 32'd0);
        chk("abort_ready_low", 32'(tx_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", 32'(tx_ready), 32'd1);
        repeat (5) @(negedge clk);

        // TURN_CYC=0, DIV=1 instance, 0x81
        fexp = PAR ? {8'h81, 1'b0} : {1'b0, 8'h81};
        f_tx_data  = 8'h81;
        f_tx_valid = 1'b1;
        n = 0;
        while (f_tx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        f_tx_valid = 1'b0;
        @(negedge clk);
        chk("fast_lat_en", 32'(f_o_en), 32'd1);
        chk("fast_busy", 32'(f_busy), 32'd1);
        for (int k = 0; k < NB; k++) begin
            if (k > 0) @(negedge clk);
            chk("fast_en", 32'(f_o_en), 32'd1);
            chk("fast_bit", 32'(f_o_dat), 32'(fexp[NB-1-k]));
        end
        @(negedge clk);
        chk("fast_en_off", 32'(f_o_en), 32'd0);
        chk("fast_dat_off", 32'(f_o_dat), 32'd0);
        chk("fast_done", 32'(f_done), 32'd1);
        chk("fast_ready", 32'(f_tx_ready), 32'd1);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
